// File: rtl/multicycle_pkg.sv
// Shared constants for the multicycle control FSM.
// Holds state codes, opcodes, mux encodings and the control bundle.
package multicycle_pkg;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_IMMEX  = 4'd8;
    localparam logic [3:0] S_IMMWB  = 4'd9;
    localparam logic [3:0] S_BRANCH = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;
    localparam logic [3:0] S_JAL    = 4'd12;
    localparam logic [3:0] S_JR     = 4'd13;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b000001;
    localparam logic [5:0] OP_SW    = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b000011;
    localparam logic [5:0] OP_SUBI  = 6'b000100;
    localparam logic [5:0] OP_BEQ   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000111;
    localparam logic [5:0] OP_JAL   = 6'b001000;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_FN  = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_REGA   = 2'b11;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] RD_RT  = 2'b00;
    localparam logic [1:0] RD_RD  = 2'b01;
    localparam logic [1:0] RD_R31 = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MEM = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       pcwrite;
        logic       branch;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] aluop;
        logic [1:0] regdst;
        logic [1:0] memtoreg;
        logic       regwrite;
        logic       illegal;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_ADDI,
            OP_SUBI, OP_BEQ, OP_J, OP_JAL: op_legal = 1'b1;
            default:                       op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_outdec.sv
// Moore output decoder: state (plus op/mem_ready qualifiers) to controls.
// Unused state codes fall through to an all-zero bundle.
module multicycle_outdec
    import multicycle_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [3:0]      state,
    input  logic [OP_W-1:0] op,
    input  logic            mem_ready,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = SRCB_4;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_IMM4;
                ctrl.illegal = ~op_legal(op);
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.memtoreg = M2R_MEM;
                ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_EXEC: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.aluop   = ALU_FN;
            end
            S_ALUWB: begin
                ctrl.regdst   = RD_RD;
                ctrl.regwrite = 1'b1;
            end
            S_IMMEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = (op == OP_SUBI) ? ALU_SUB : ALU_ADD;
            end
            S_IMMWB: begin
                ctrl.regdst   = RD_RT;
                ctrl.regwrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALU_SUB;
                ctrl.branch  = 1'b1;
                ctrl.pcsrc   = PC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = PC_JUMP;
            end
            S_JAL: begin
                ctrl.pcwrite  = 1'b1;
                ctrl.pcsrc    = PC_JUMP;
                ctrl.regdst   = RD_R31;
                ctrl.memtoreg = M2R_PC;
                ctrl.regwrite = 1'b1;
            end
            S_JR: begin
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = PC_REGA;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle Moore control FSM with memory stall and retired-instr counter.
// Controls are gated to zero while rst_n is low.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [OP_W-1:0]    op,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               mem_req,
    output logic               memwrite,
    output logic               iord,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               branch,
    output logic [1:0]         pcsrc,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         aluop,
    output logic [1:0]         regdst,
    output logic [1:0]         memtoreg,
    output logic               regwrite,
    output logic               illegal,
    output logic [CNT_W-1:0]   instret,
    output logic [3:0]         state_o
);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;
    ctrl_t            ctrl, ctrl_g;
    logic             unused_zero;

    // zero is consumed by the datapath's pcen, not by sequencing
    assign unused_zero = zero;

    always_comb begin
        state_d = S_FETCH;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:     state_d = S_MEMADR;
                    OP_RTYPE:         state_d = (funct == FN_JR) ? S_JR
                                                                 : S_EXEC;
                    OP_ADDI, OP_SUBI: state_d = S_IMMEX;
                    OP_BEQ:           state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_JAL:           state_d = S_JAL;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR: begin
                state_d = mem_ready ? S_FETCH : S_MEMWR;
                retire  = mem_ready;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_IMMEX:  state_d = S_IMMWB;
            S_MEMWB, S_ALUWB, S_IMMWB,
            S_BRANCH, S_JUMP, S_JAL, S_JR: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default:  state_d = S_FETCH;
        endcase
        instret_d = instret_q + CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    multicycle_outdec #(.OP_W(OP_W)) u_outdec (
        .state     (state_q),
        .op        (op),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign ctrl_g   = rst_n ? ctrl : '0;
    assign state_o  = rst_n ? state_q : S_FETCH;
    assign instret  = instret_q;

    assign mem_req  = ctrl_g.mem_req;
    assign memwrite = ctrl_g.memwrite;
    assign iord     = ctrl_g.iord;
    assign irwrite  = ctrl_g.irwrite;
    assign pcwrite  = ctrl_g.pcwrite;
    assign branch   = ctrl_g.branch;
    assign pcsrc    = ctrl_g.pcsrc;
    assign alusrca  = ctrl_g.alusrca;
    assign alusrcb  = ctrl_g.alusrcb;
    assign aluop    = ctrl_g.aluop;
    assign regdst   = ctrl_g.regdst;
    assign memtoreg = ctrl_g.memtoreg;
    assign regwrite = ctrl_g.regwrite;
    assign illegal  = ctrl_g.illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: instruction-level model feeds
// a per-cycle expectation queue that a monitor drains at negedge.
module tb_multicycle_ctrl;

    localparam int P_FETCH = 0, P_DECODE = 1, P_MEMADR = 2, P_MEMRD = 3;
    localparam int P_MEMWB = 4, P_MEMWR = 5, P_EXEC = 6, P_ALUWB = 7;
    localparam int P_IMMEX = 8, P_IMMWB = 9, P_BRANCH = 10, P_JUMP = 11;
    localparam int P_JAL = 12, P_JR = 13;

    typedef struct packed {
        logic [3:0]  st;
        logic        mem_req, memwrite, iord, irwrite, pcwrite, branch;
        logic [1:0]  pcsrc;
        logic        alusrca;
        logic [1:0]  alusrcb, aluop, regdst, memtoreg;
        logic        regwrite, illegal;
        logic [31:0] instret;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  op = '0, funct = '0;
    logic        zero = 1'b0, mem_ready = 1'b0;
    logic        mem_req, memwrite, iord, irwrite, pcwrite, branch;
    logic [1:0]  pcsrc, alusrcb, aluop, regdst, memtoreg;
    logic        alusrca, regwrite, illegal;
    logic [31:0] instret;
    logic [3:0]  state_o;

    int   checks = 0;
    int   errors = 0;
    int   cnt_m  = 0;
    obs_t expq[$];
    obs_t act;

    always #5 clk = ~clk;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
        .iord(iord), .irwrite(irwrite), .pcwrite(pcwrite),
        .branch(branch), .pcsrc(pcsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .regdst(regdst),
        .memtoreg(memtoreg), .regwrite(regwrite), .illegal(illegal),
        .instret(instret), .state_o(state_o)
    );

    always_comb begin
        act          = '0;
        act.st       = state_o;
        act.mem_req  = mem_req;
        act.memwrite = memwrite;
        act.iord     = iord;
        act.irwrite  = irwrite;
        act.pcwrite  = pcwrite;
        act.branch   = branch;
        act.pcsrc    = pcsrc;
        act.alusrca  = alusrca;
        act.alusrcb  = alusrcb;
        act.aluop    = aluop;
        act.regdst   = regdst;
        act.memtoreg = memtoreg;
        act.regwrite = regwrite;
        act.illegal  = illegal;
        act.instret  = instret;
    end

    function automatic logic is_legal(input logic [5:0] o);
        return o inside {6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd7, 6'd8};
    endfunction

    // Expected outputs for one cycle, straight from the per-phase rules
    function automatic obs_t expect_obs(input int ph, input logic [5:0] o,
                                        input logic mr, input logic rn,
                                        input int cnt);
        obs_t e;
        e = '0;
        e.instret = cnt;
        if (!rn) return e;
        e.st = 4'(ph);
        case (ph)
            P_FETCH: begin
                e.mem_req = 1; e.alusrcb = 2'b01;
                e.irwrite = mr; e.pcwrite = mr;
            end
            P_DECODE: begin
                e.alusrcb = 2'b11; e.illegal = !is_legal(o);
            end
            P_MEMADR: begin e.alusrca = 1; e.alusrcb = 2'b10; end
            P_MEMRD:  begin e.mem_req = 1; e.iord = 1; end
            P_MEMWB:  begin e.memtoreg = 2'b01; e.regwrite = 1; end
            P_MEMWR:  begin e.mem_req = 1; e.memwrite = 1; e.iord = 1; end
            P_EXEC:   begin e.alusrca = 1; e.aluop = 2'b10; end
            P_ALUWB:  begin e.regdst = 2'b01; e.regwrite = 1; end
            P_IMMEX: begin
                e.alusrca = 1; e.alusrcb = 2'b10;
                e.aluop = (o == 6'd4) ? 2'b01 : 2'b00;
            end
            P_IMMWB:  e.regwrite = 1;
            P_BRANCH: begin
                e.alusrca = 1; e.aluop = 2'b01;
                e.branch = 1; e.pcsrc = 2'b01;
            end
            P_JUMP:   begin e.pcwrite = 1; e.pcsrc = 2'b10; end
            P_JAL: begin
                e.pcwrite = 1; e.pcsrc = 2'b10; e.regdst = 2'b10;
                e.memtoreg = 2'b10; e.regwrite = 1;
            end
            P_JR:     begin e.pcwrite = 1; e.pcsrc = 2'b11; end
            default:  e = '0;
        endcase
        return e;
    endfunction

    task automatic cyc(input int ph, input logic [5:0] o,
                       input logic [5:0] f, input logic mr,
                       input logic rn);
        op = o; funct = f; mem_ready = mr; rst_n = rn;
        zero = 1'($urandom);
        expq.push_back(expect_obs(ph, o, mr, rn, cnt_m));
        @(posedge clk);
        #1;
        if (!rn) cnt_m = 0;
    endtask

    task automatic mem_phase(input int ph, input logic [5:0] o,
                             input logic [5:0] f, input int waits);
        for (int i = 0; i < waits; i++) cyc(ph, o, f, 1'b0, 1'b1);
        cyc(ph, o, f, 1'b1, 1'b1);
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int fw, input int mw);
        int route[$];
        logic [5:0] junk;
        junk = 6'($urandom);
        mem_phase(P_FETCH, junk, f, fw);
        cyc(P_DECODE, o, f, 1'($urandom), 1'b1);
        if (!is_legal(o)) return;
        case (o)
            6'd1: route = '{P_MEMADR, P_MEMRD, P_MEMWB};
            6'd2: route = '{P_MEMADR, P_MEMWR};
            6'd0: if (f == 6'd8) route = '{P_JR};
                  else route = '{P_EXEC, P_ALUWB};
            6'd3, 6'd4: route = '{P_IMMEX, P_IMMWB};
            6'd5: route = '{P_BRANCH};
            6'd7: route = '{P_JUMP};
            default: route = '{P_JAL};
        endcase
        foreach (route[k]) begin
            if (route[k] == P_MEMRD || route[k] == P_MEMWR)
                mem_phase(route[k], o, f, mw);
            else
                cyc(route[k], o, f, 1'($urandom), 1'b1);
        end
        cnt_m++;
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL ctrl st=%0d got=%h want=%h",
                             e.st, act, e);
                end
            end
        end
    end

    initial begin : driver
        logic [5:0] lops [8];
        logic [5:0] o, f;
        lops = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd7, 6'd8};
        @(posedge clk);
        #1;
        cyc(P_FETCH, 6'd0, 6'd0, 1'b1, 1'b0);
        cyc(P_FETCH, 6'd1, 6'd0, 1'b0, 1'b0);
        run_instr(6'd1, 6'd0, 0, 0);
        run_instr(6'd2, 6'd0, 0, 3);
        run_instr(6'd0, 6'b100000, 0, 0);
        run_instr(6'd0, 6'b001000, 0, 0);
        run_instr(6'd8, 6'd0, 0, 0);
        run_instr(6'd5, 6'd0, 0, 0);
        run_instr(6'd7, 6'd0, 1, 0);
        run_instr(6'd3, 6'd0, 0, 0);
        run_instr(6'd4, 6'd0, 2, 0);
        run_instr(6'b101010, 6'd0, 0, 0);
        run_instr(6'd1, 6'd0, 0, 2);
        // abandon a load mid-MEMRD
        mem_phase(P_FETCH, 6'd0, 6'd0, 0);
        cyc(P_DECODE, 6'd1, 6'd0, 1'b1, 1'b1);
        cyc(P_MEMADR, 6'd1, 6'd0, 1'b1, 1'b1);
        cyc(P_MEMRD, 6'd1, 6'd0, 1'b0, 1'b1);
        cyc(P_MEMRD, 6'd1, 6'd0, 1'b1, 1'b0);
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) != 0) o = lops[$urandom_range(0, 7)];
            else o = 6'($urandom);
            f = ($urandom_range(0, 2) == 0) ? 6'd8 : 6'($urandom);
            run_instr(o, f, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        repeat (2) @(negedge clk);
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got=%0d want=0", expq.size());
        end
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle successor to the single-cycle main decoder: a Moore control FSM that sequences fetch, decode, execute, memory and writeback across several cycles.
- Stalls on a memory ready handshake and skips illegal opcodes with a one-cycle flag.
- Keeps a retired-instruction counter.
- Sits between the instruction register (supplies op/funct) and the shared-ALU/shared-memory datapath.

Parameters:
- OP_W, 6, opcode width.
- FUNCT_W, 6, funct width.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- op  in  OP_W  opcode from IR; valid from DECODE onward
- funct  in  FUNCT_W  funct from IR
- zero  in  1  ALU zero (not used by FSM; documented pass-through for datapath pcen)
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory access active
- memwrite  out  1  access is a write (qualified by mem_req)
- iord  out  1  0 = PC address, 1 = ALUOut address
- irwrite  out  1  load IR
- pcwrite  out  1  unconditional PC load
- branch  out  1  PC load if zero (datapath forms pcen = pcwrite | branch&zero)
- pcsrc  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 register A (jr)
- alusrca  out  1  0 = PC, 1 = reg A
- alusrcb  out  2  00 reg B, 01 const 4, 10 signext imm, 11 signext imm<<2
- aluop  out  2  00 add, 01 sub, 10 per funct, 11 reserved/unused
- regdst  out  2  00 rt, 01 rd, 10 r31
- memtoreg  out  2  00 ALUOut, 01 mem data, 10 PC
- regwrite  out  1  register file write
- illegal  out  1  one-cycle pulse on undefined op
- instret  out  CNT_W  retired legal instruction count
- state_o  out  4  current state (debug)

Behaviour:
- Reset: rst_n low at an edge → state FETCH, instret 0. While rst_n is low, all control outputs are forced 0 and state_o = FETCH.
- Outputs not listed for a state are 0.
- Opcodes:
  - RTYPE 000000 (funct 001000 = JR)
  - LW 000001
  - SW 000010
  - ADDI 000011
  - SUBI 000100
  - BEQ 000101
  - J 000111
  - JAL 001000
  - all others illegal
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, aluop=00, pcsrc=00. irwrite and pcwrite are asserted only when mem_ready=1. Stay in FETCH while mem_ready=0; on mem_ready=1 → DECODE.
- DECODE: alusrca=0, alusrcb=11, aluop=00 (branch target into ALUOut). Next state by op:
  - LW/SW → MEMADR
  - RTYPE with funct≠JR → EXEC; with funct=JR → JR
  - ADDI/SUBI → IMMEX
  - BEQ → BRANCH
  - J → JUMP
  - JAL → JAL
  - illegal: illegal=1 this cycle → FETCH, not counted
- MEMADR: alusrca=1, alusrcb=10, aluop=00. → MEMRD (LW) or MEMWR (SW).
- MEMRD: mem_req=1, iord=1. Hold until mem_ready → MEMWB.
- MEMWB: regdst=00, memtoreg=01, regwrite=1 → FETCH.
- MEMWR: mem_req=1, memwrite=1, iord=1. Hold until mem_ready → FETCH.
- EXEC: alusrca=1, alusrcb=00, aluop=10 → ALUWB.
- ALUWB: regdst=01, memtoreg=00, regwrite=1 → FETCH.
- IMMEX: alusrca=1, alusrcb=10, aluop=00 (ADDI) or 01 (SUBI) → IMMWB.
- IMMWB: regdst=00, memtoreg=00, regwrite=1 → FETCH.
- BRANCH: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsrc=01 → FETCH.
- JUMP: pcwrite=1, pcsrc=10 → FETCH.
- JAL: pcwrite=1, pcsrc=10, regdst=10, memtoreg=10, regwrite=1 → FETCH. PC already holds PC+4.
- JR: pcwrite=1, pcsrc=11 → FETCH.
- Latency with mem_ready tied to 1:
  - 3 cycles: BEQ, J, JAL, JR
  - 4 cycles: R, ADDI, SUBI, SW
  - 5 cycles: LW
  - Each memory state adds one cycle per mem_ready=0 cycle.
- instret: +1 on the cycle a legal instruction's final state transitions to FETCH. Wraps modulo 2^CNT_W.
- Mid-operation reset: abandons the instruction and drops mem_req on that edge's output gating; no count.
- Unused state encodings → FETCH next cycle, outputs 0.

Decomposition:
- Package multicycle_pkg holds the state enum (4-bit: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, IMMEX, IMMWB, BRANCH, JUMP, JAL, JR), the opcode/JR-funct constants, and the aluop/pcsrc/alusrcb/regdst/memtoreg encodings.
- One combinational sub-module, multicycle_outdec (state, op, mem_ready → control outputs); FSM and counter stay in top.

Test Plan:
- Reset: hold rst_n=0 two cycles, release → all outputs 0 during reset; state_o=FETCH, mem_req=1, instret=0 the cycle after release.
- LW, mem_ready=1 → states FETCH,DECODE,MEMADR,MEMRD,MEMWB; regwrite=1 with memtoreg=01 in cycle 5; instret=1.
- SW with mem_ready low 3 cycles in MEMWR → memwrite held 4 cycles, no regwrite, 7 total cycles, instret +1.
- R-type funct 100000, then funct 001000 → EXEC/ALUWB with aluop=10, regdst=01; then JR with pcsrc=11, pcwrite=1 in cycle 3.
- JAL → cycle 3: pcwrite=1, pcsrc=10, regdst=10, memtoreg=10, regwrite=1. BEQ → cycle 3: branch=1, aluop=01, pcsrc=01.
- op=101010 → illegal=1 for exactly the DECODE cycle, next state FETCH, instret unchanged. Then rst_n=0 during MEMRD → FETCH, instret 0.
